instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Packs symbolic instruction descriptors (op, rs, rt, rd, imm) into 32-bit words in the core's ISA encoding.
//  Writes the packed words to consecutive instruction-memory addresses.
//  Sits between the program loader/test driver and the imem write port.
//  Every word it emits must decode back to the same op/registers/immediate in the core control decoder.
// PARAMETERS
//  AW   10  imem word-address width; addresses wrap modulo 2**AW
// PORTS
//  clk            in   1      clock, rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  start          in   1      1-cycle pulse; latches base_addr/count; ignored unless IDLE
//  base_addr      in   AW     first imem word address
//  count          in   AW+1   number of descriptors to encode (0 allowed)
//  in_valid       in   1      descriptor valid
//  in_ready       out  1      descriptor accepted when in_valid&in_ready
//  in_op          in   5      op enum, see BEHAVIOUR
//  in_rs/in_rt/in_rd in 5     register fields
//  in_imm         in   32     imm16 / shamt[4:0] / jump target[25:0]
//  imem_we        out  1      write strobe
//  imem_addr      out  AW     write address
//  imem_wdata     out  32     encoded instruction
//  busy           out  1      state != IDLE
//  done           out  1      1-cycle pulse at end of block
//  err_op         out  1      sticky: invalid op seen since start
//  err_range      out  1      sticky: immediate/target out of range since start
//  words_written  out  AW+1   words written since last start
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, imem_we, done, err_op, err_range = 0; imem_addr, imem_wdata, words_written = 0.
//  FSM IDLE -> RUN on start (count!=0); IDLE -> FLUSH on start with count==0.
//   RUN -> FLUSH when count-th descriptor is accepted. FLUSH -> IDLE next cycle; done=1 in FLUSH.
//  start clears err_op, err_range and words_written and loads the address pointer.
//  in_ready = (state==RUN) && (accepted < count). No bubbles: one descriptor per cycle sustained.
//  Latency 1: a descriptor accepted in cycle N gives imem_we=1 in cycle N+1 with registered addr/wdata.
//   The pointer increments after each write, wrapping 2**AW-1 -> 0.
//   words_written increments with each imem_we.
//  Op enum -> encoding {opcode,rs,rt,rd,shamt,funct} / {opcode,rs,rt,imm16} / {opcode,target26}:
//   0 add f=20h, 1 addu 21h, 2 sub 22h, 3 subu 23h, 4 and 24h, 5 or 25h, 8 slt 2Ah : opcode 0, rs,rt,rd, shamt=0.
//   6 sll f=00h, 7 srl f=02h : opcode 0, rs=0, rt, rd, shamt=imm[4:0].
//   9 jr f=08h : opcode 0, rs, rt=rd=shamt=0.
//   10 addi 08h, 11 addiu 09h, 12 slti 0Ah, 13 sltiu 0Bh, 14 andi 0Ch, 15 ori 0Dh : opcode, rs, rt, imm[15:0].
//   16 beq 18h, 17 bne 19h, 18 bgt 1Ah, 19 bgte 1Bh, 20 ble 1Ch, 21 bleq 1Eh : opcode, rs, rt, imm[15:0].
//   22 lw 23h, 23 sw 2Bh : opcode, rs (base), rt, imm[15:0].
//   24 j 02h, 25 jal 03h : opcode, target=imm[25:0].
//  Range checks (word still written, truncated; err_range set):
//   Signed ops (addi, slti, branches, lw, sw): imm[31:15] must be all-equal.
//   Unsigned ops (addiu, sltiu, andi, ori): imm[31:16] must be 0.
//   sll/srl: imm[31:5] must be 0. j/jal: imm[31:26] must be 0.
//  in_op >= 26: write 32'h0000_0000 (nop) at that slot and set err_op; the block continues.
//  Unused descriptor fields are ignored and never range-checked.
//  reset_n low mid-block: immediate return to IDLE with reset values; a pending write is dropped.
// TESTING
//  1 start base=0,count=1; add rs=1,rt=2,rd=3 -> cycle after accept: we=1, addr=0, wdata=0x00221820; done next cycle.
//  2 addi rs=0,rt=5,imm=-1 -> 0x2005FFFF, err_range=0. ori rs=1,rt=1,imm=0x10000 -> 0x34210000, err_range=1.
//  3 lw rs=2,rt=4,imm=8 -> 0x8C440008. jal imm=0x100 -> 0x0C000100. op=31 -> wdata=0, err_op=1.
//  4 base=2**AW-2, count=4, back-to-back valid -> addrs 3FE,3FF,000,001 on consecutive cycles; words_written=4.
//  5 count=0 -> no imem_we, done 1 cycle after start. start while busy -> ignored. in_valid gaps -> no spurious we.
//  6 reset_n low mid-block -> outputs at reset values at once; new start accepted after release; errors cleared.

Source files
------------

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: descriptor stream in, imem write port out
// master: descriptor source / imem sink; slave: the encoder
interface instr_encoder_if #(parameter int AW = 10);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [31:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs op/rs/rt/rd/imm descriptors into ISA words, writes them to consecutive imem addresses
// clk, reset_n (async, active-low); start/base_addr/count launch a block of count descriptors
// bus: descriptor valid/ready stream and registered imem write port (1-cycle latency)
// busy/done status, sticky err_op/err_range, words_written since last start
module instr_encoder #(parameter int AW = 10) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    instr_encoder_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic          err_op,
    output logic          err_range,
    output logic [AW:0]   words_written
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nx;
    logic [AW:0]   total, accepted;
    logic [AW-1:0] ptr;
    logic          go, accept, last;
    logic [31:0]   enc, imm;
    logic          bad_op, bad_rng, sfit, ufit;
    logic [19:0]   rfld;
    logic [25:0]   ifld;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx     = state;
        bus.in_ready = state == RUN && accepted < total;
        busy         = state != IDLE;
        done         = state == FLUSH;
        go           = start && state == IDLE;
        accept       = bus.in_valid && bus.in_ready;
        last         = accept && accepted + 1'b1 == total;
        case (state)
            IDLE:    if (start) state_nx = count == '0 ? FLUSH : RUN;
            RUN:     if (last) state_nx = FLUSH;
            default: state_nx = IDLE;
        endcase
    end
    assign imm  = bus.in_imm;
    // signed imm16 fits when the sign bit and everything above agree
    assign sfit = &imm[31:15] | ~|imm[31:15];
    assign ufit = ~|imm[31:16];
    assign rfld = {bus.in_rs, bus.in_rt, bus.in_rd, 5'd0};
    assign ifld = {bus.in_rs, bus.in_rt, imm[15:0]};
    always_comb begin
        enc     = '0;
        bad_op  = 1'b0;
        bad_rng = 1'b0;
        case (bus.in_op)
            5'd0:    enc = {6'h00, rfld, 6'h20};
            5'd1:    enc = {6'h00, rfld, 6'h21};
            5'd2:    enc = {6'h00, rfld, 6'h22};
            5'd3:    enc = {6'h00, rfld, 6'h23};
            5'd4:    enc = {6'h00, rfld, 6'h24};
            5'd5:    enc = {6'h00, rfld, 6'h25};
            5'd6:    {enc, bad_rng} = {11'd0, bus.in_rt, bus.in_rd, imm[4:0], 6'h00, |imm[31:5]};
            5'd7:    {enc, bad_rng} = {11'd0, bus.in_rt, bus.in_rd, imm[4:0], 6'h02, |imm[31:5]};
            5'd8:    enc = {6'h00, rfld, 6'h2a};
            5'd9:    enc = {6'h00, bus.in_rs, 15'd0, 6'h08};
            5'd10:   {enc, bad_rng} = {6'h08, ifld, !sfit};
            5'd11:   {enc, bad_rng} = {6'h09, ifld, !ufit};
            5'd12:   {enc, bad_rng} = {6'h0a, ifld, !sfit};
            5'd13:   {enc, bad_rng} = {6'h0b, ifld, !ufit};
            5'd14:   {enc, bad_rng} = {6'h0c, ifld, !ufit};
            5'd15:   {enc, bad_rng} = {6'h0d, ifld, !ufit};
            5'd16:   {enc, bad_rng} = {6'h18, ifld, !sfit};
            5'd17:   {enc, bad_rng} = {6'h19, ifld, !sfit};
            5'd18:   {enc, bad_rng} = {6'h1a, ifld, !sfit};
            5'd19:   {enc, bad_rng} = {6'h1b, ifld, !sfit};
            5'd20:   {enc, bad_rng} = {6'h1c, ifld, !sfit};
            5'd21:   {enc, bad_rng} = {6'h1e, ifld, !sfit};
            5'd22:   {enc, bad_rng} = {6'h23, ifld, !sfit};
            5'd23:   {enc, bad_rng} = {6'h2b, ifld, !sfit};
            5'd24:   {enc, bad_rng} = {6'h02, imm[25:0], |imm[31:26]};
            5'd25:   {enc, bad_rng} = {6'h03, imm[25:0], |imm[31:26]};
            default: bad_op = 1'b1;
        endcase
    end
    // go only happens in IDLE and accept only in RUN, so they never collide
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            total          <= '0;
            accepted       <= '0;
            ptr            <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            err_op         <= 1'b0;
            err_range      <= 1'b0;
            words_written  <= '0;
        end else begin
            bus.imem_we <= accept;
            if (bus.imem_we) words_written <= words_written + 1'b1;
            if (go) begin
                total         <= count;
                accepted      <= '0;
                ptr           <= base_addr;
                err_op        <= 1'b0;
                err_range     <= 1'b0;
                words_written <= '0;
            end
            if (accept) begin
                accepted       <= accepted + 1'b1;
                ptr            <= ptr + 1'b1;
                bus.imem_addr  <= ptr;
                bus.imem_wdata <= enc;
                err_op         <= err_op | bad_op;
                err_range      <= err_range | bad_rng;
            end
        end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized + directed check of instr_encoder against an arithmetic ISA model
module tb_instr_encoder;
    localparam int AW = 10;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          busy, done, err_op, err_range;
    logic [AW:0]   words_written;
    instr_encoder_if #(.AW(AW)) bus ();
    instr_encoder #(.AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
        .bus(bus), .busy(busy), .done(done), .err_op(err_op), .err_range(err_range),
        .words_written(words_written)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    int r_funct [10] = '{32, 33, 34, 35, 36, 37, 0, 2, 42, 8};
    int i_opc   [16] = '{8, 9, 10, 11, 12, 13, 24, 25, 26, 27, 28, 30, 35, 43, 2, 3};
    int q_op[$], q_rs[$], q_rt[$], q_rd[$];
    logic [31:0] q_imm[$];
    int exp_addr[$];
    logic [31:0] exp_data[$];
    int m_ptr;
    bit m_eop, m_erng;
    logic [31:0] last_addr = '0, last_wdata = '0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt, input int rd,
                                            input logic [31:0] imm, output bit rerr);
        longint u, s, w;
        bit sh, sgn;
        u = longint'(imm);
        s = longint'($signed(imm));
        rerr = 0;
        w = 0;
        sh = (op == 6 || op == 7);
        sgn = !(op inside {11, 13, 14, 15});
        if (op >= 26) return 32'h0;
        if (op <= 9) begin
            w = longint'(sh ? 0 : rs) * 2097152 + longint'(op == 9 ? 0 : rt) * 65536
              + longint'(op == 9 ? 0 : rd) * 2048 + (sh ? u % 32 : 0) * 64 + r_funct[op];
            rerr = sh && u >= 32;
        end else if (op <= 23) begin
            w = longint'(i_opc[op-10]) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + u % 65536;
            rerr = sgn ? (s < -32768 || s > 32767) : (u > 65535);
        end else begin
            w = longint'(i_opc[op-10]) * 67108864 + u % 67108864;
            rerr = u >= 67108864;
        end
        return w[31:0];
    endfunction
    always @(negedge clk)
        if (reset_n && bus.imem_we) begin
            last_addr = 32'(bus.imem_addr);
            last_wdata = bus.imem_wdata;
            if (exp_data.size() == 0) check("spurious_we", 32'd1, 32'd0);
            else begin
                check("imem_addr", last_addr, 32'(exp_addr.pop_front()));
                check("imem_wdata", last_wdata, exp_data.pop_front());
            end
        end
    task automatic add_desc(input int op, input int rs, input int rt, input int rd, input logic [31:0] imm);
        q_op.push_back(op); q_rs.push_back(rs); q_rt.push_back(rt); q_rd.push_back(rd); q_imm.push_back(imm);
    endtask
    task automatic add_random(input int n);
        logic [31:0] imm;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0:       imm = $urandom_range(0, 40);
                1:       imm = $urandom_range(0, 65535) - 32768;
                2:       imm = $urandom;
                default: imm = $urandom_range(0, 67108900);
            endcase
            add_desc($urandom_range(0, 9) == 0 ? $urandom_range(26, 31) : $urandom_range(0, 25),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
        end
    endtask
    task automatic clear_desc();
        q_op.delete(); q_rs.delete(); q_rt.delete(); q_rd.delete(); q_imm.delete();
    endtask
    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_errs"}, 32'({err_op, err_range}), 32'd0);
        check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
        check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_words"}, 32'(words_written), 32'd0);
    endtask
    task automatic run_block(input int base, input int gap_max, input bit restart_mid, input int abort_at);
        int n, t;
        bit rdy, rerr;
        logic [31:0] w;
        n = q_op.size();
        start = 1'b1;
        base_addr = AW'(base);
        count = (AW+1)'(n);
        m_ptr = base;
        m_eop = 0;
        m_erng = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                reset_n = 1'b0;
                #1;
                check_reset_values("abort");
                exp_addr.delete();
                exp_data.delete();
                bus.in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 reset_n = 1'b1;
                clear_desc();
                return;
            end
            if (gap_max > 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            end
            bus.in_op = 5'(q_op[i]); bus.in_rs = 5'(q_rs[i]); bus.in_rt = 5'(q_rt[i]);
            bus.in_rd = 5'(q_rd[i]); bus.in_imm = q_imm[i];
            bus.in_valid = 1'b1;
            if (restart_mid && i == 1) begin
                start = 1'b1;
                base_addr = AW'(base + 100);
                count = 7;
            end
            t = 0;
            forever begin
                @(negedge clk);
                rdy = bus.in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                if (rdy) break;
                t++;
                if (t > 50) begin
                    check("ready_timeout", 32'(t), 32'd0);
                    break;
                end
            end
            if (gap_max == 0) check("no_bubble", 32'(t), 32'd0);
            if (rdy) begin
                w = ref_enc(q_op[i], q_rs[i], q_rt[i], q_rd[i], q_imm[i], rerr);
                exp_addr.push_back(m_ptr);
                exp_data.push_back(w);
                m_ptr = (m_ptr + 1) % (2**AW);
                m_eop |= q_op[i] >= 26;
                m_erng |= rerr;
            end
        end
        bus.in_valid = 1'b0;
        t = 0;
        while (!done && t < 20) begin @(posedge clk); #1; t++; end
        check("done_latency", 32'(t), 32'd0);
        check("done", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("words_written", 32'(words_written), 32'(n));
        check("err_op", 32'(err_op), 32'(m_eop));
        check("err_range", 32'(err_range), 32'(m_erng));
        check("drained", 32'(exp_data.size()), 32'd0);
        clear_desc();
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        add_desc(0, 1, 2, 3, 0);
        run_block(0, 0, 0, -1);
        check("t1_wdata", last_wdata, 32'h0022_1820);
        check("t1_addr", last_addr, 32'd0);
        add_desc(10, 0, 5, 0, 32'hFFFF_FFFF);
        run_block(3, 0, 0, -1);
        check("t2_addi", last_wdata, 32'h2005_FFFF);
        check("t2_addi_rng", 32'(err_range), 32'd0);
        add_desc(15, 1, 1, 0, 32'h0001_0000);
        run_block(4, 0, 0, -1);
        check("t2_ori", last_wdata, 32'h3421_0000);
        check("t2_ori_rng", 32'(err_range), 32'd1);
        add_desc(22, 2, 4, 0, 8);
        run_block(5, 0, 0, -1);
        check("t3_lw", last_wdata, 32'h8C44_0008);
        add_desc(25, 0, 0, 0, 32'h100);
        run_block(6, 0, 0, -1);
        check("t3_jal", last_wdata, 32'h0C00_0100);
        add_desc(31, 7, 7, 7, 32'h1234);
        run_block(7, 0, 0, -1);
        check("t3_nop", last_wdata, 32'h0);
        check("t3_err_op", 32'(err_op), 32'd1);
        for (int i = 0; i < 4; i++) add_desc(i, i, i + 1, i + 2, 0);
        run_block(2**AW - 2, 0, 0, -1);
        check("t4_last_addr", last_addr, 32'd1);
        check("t4_words", 32'(words_written), 32'd4);
        run_block(30, 0, 0, -1);
        add_random(3);
        run_block(10, 0, 1, -1);
        add_random(6);
        run_block(20, 3, 0, -1);
        add_desc(31, 0, 0, 0, 0);
        add_random(4);
        run_block(40, 0, 0, 3);
        add_random(2);
        run_block(50, 0, 0, -1);
        for (int b = 0; b < 25; b++) begin
            add_random($urandom_range(0, 12));
            run_block($urandom_range(0, 2**AW - 1), $urandom_range(0, 2), 1'b0, -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
